// File: rtl/serial_sub_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_sub_pkg
// Brief    : Mode constants and FSM state type for the bit-serial subtract unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_sub_pkg;

    localparam logic [1:0] MODE_SUB  = 2'd0;
    localparam logic [1:0] MODE_ONES = 2'd1;
    localparam logic [1:0] MODE_TWOS = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_sub_unit_full_sub_bit.sv
//------------------------------------------------------------------------------
// Module   : full_sub_bit
// Brief    : One-bit full subtractor, d = x - y - bin with borrow-out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bin;
    assign bout = (~x & y) | (~w_xy & bin);

endmodule

`default_nettype wire

// File: rtl/serial_sub_unit.sv
//------------------------------------------------------------------------------
// Module   : serial_sub_unit
// Brief    : Bit-serial A-B / ~A / 0-A unit, LSB first, start/done handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_sub_unit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             overflow
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [1:0]       r_mode;
    logic             r_bin;
    logic [WIDTH-1:0] r_result;
    logic             r_borrow;
    logic             r_overflow;

    logic w_ones, w_twos, w_last;
    logic w_x, w_y, w_d_fs, w_bout_fs, w_d, w_bout;

    assign w_ones = (r_mode == MODE_ONES);
    assign w_twos = (r_mode == MODE_TWOS);
    assign w_last = (r_cnt == c_last);

    // Two's complement is 0 - A, so A moves to the subtrahend input.
    assign w_x = w_twos ? 1'b0 : r_a_sh[0];
    assign w_y = w_twos ? r_a_sh[0] : r_b_sh[0];

    full_sub_bit u_fsb (
        .x    (w_x),
        .y    (w_y),
        .bin  (r_bin),
        .d    (w_d_fs),
        .bout (w_bout_fs)
    );

    assign w_d    = w_ones ? ~r_a_sh[0] : w_d_fs;
    assign w_bout = w_ones ? 1'b0 : w_bout_fs;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_mode     <= MODE_SUB;
            r_bin      <= 1'b0;
            r_result   <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_mode <= mode;
                r_cnt  <= '0;
                r_bin  <= 1'b0;
            end else if (r_state == RUN) begin
                r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_res_sh <= {w_d, r_res_sh[WIDTH-1:1]};
                r_bin    <= w_bout;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    // On the MSB, w_x/w_y are the sign bits of the effective operands.
                    r_result   <= {w_d, r_res_sh[WIDTH-1:1]};
                    r_borrow   <= w_bout;
                    r_overflow <= ~w_ones & (w_x ^ w_y) & (w_d ^ w_x);
                end
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign result   = r_result;
    assign borrow   = r_borrow;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_sub_unit
// Brief    : Scoreboard bench for serial_sub_unit at WIDTH=8.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done, borrow, overflow;
    logic [7:0] result;

    serial_sub_unit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] res;
        logic       bor;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("result", {24'd0, result}, {24'd0, e.res});
                chk("borrow", {31'd0, borrow}, {31'd0, e.bor});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (n_done < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n_done < target) chk("done_timeout", n_done, target);
    endtask

    task automatic run_op(input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] er, input logic eb, input logic eo);
        exp_t e;
        int   target;
        wait_idle();
        mode  = m;
        a     = va;
        b     = vb;
        start = 1'b1;
        e.cyc = cyc + 1 + 8;
        e.res = er;
        e.bor = eb;
        e.ov  = eo;
        q.push_back(e);
        target = n_done + 1;
        @(negedge clk);
        start = 1'b0;
        wait_dones(target);
    endtask

    initial begin
        exp_t e;
        int   target;

        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_borrow", {31'd0, borrow}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(2'd0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(2'd0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(2'd0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(2'd1, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0);
        run_op(2'd2, 8'h01, 8'h77, 8'hFF, 1'b1, 1'b0);
        run_op(2'd2, 8'h80, 8'h00, 8'h80, 1'b1, 1'b1);
        run_op(2'd2, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op(2'd3, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // Operand change and extra start while running are ignored.
        wait_idle();
        mode = 2'd0; a = 8'h05; b = 8'h03; start = 1'b1;
        e.cyc = cyc + 1 + 8; e.res = 8'h02; e.bor = 1'b0; e.ov = 1'b0;
        q.push_back(e);
        target = n_done + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; mode = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dones(target);
        repeat (12) @(negedge clk);
        chk("single_done", n_done, target);

        // Start held high: completions every 10 cycles.
        wait_idle();
        mode = 2'd0; a = 8'h05; b = 8'h03; start = 1'b1;
        target = n_done + 3;
        for (int k = 0; k < 3; k++) begin
            e.cyc = cyc + 1 + 8 + 10 * k; e.res = 8'h02; e.bor = 1'b0; e.ov = 1'b0;
            q.push_back(e);
        end
        wait_dones(target);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_start_count", n_done, target);

        // Reset mid-RUN aborts without a done pulse.
        run_op(2'd0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        wait_idle();
        mode = 2'd0; a = 8'h09; b = 8'h02; start = 1'b1;
        target = n_done;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_borrow", {31'd0, borrow}, 32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", n_done, target);
        run_op(2'd0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_sub_unit.md
# serial_sub_unit

Bit-serial arithmetic unit that computes A−B, one's complement of A, or two's complement of A over a parametrised word width, one bit per clock, LSB first. It generalises the combinational half-subtractor and complement logic into one time-multiplexed datapath with a start/done handshake. It sits between the switch-sampling front end and the LED/display register on the lab board.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  operation select: 0 = A−B, 1 = ~A, 2 = 0−A, 3 = reserved (executes as A−B).
- a  in  WIDTH  operand A (minuend / complement source).
- b  in  WIDTH  operand B (subtrahend; ignored in modes 1, 2).
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse, result valid.
- result  out  WIDTH  registered result; holds until next completion.
- borrow  out  1  final borrow-out (unsigned A<B; for mode 2, A≠0; mode 1 always 0).
- overflow  out  1  signed overflow (mode 0: a[MSB]≠b[MSB] and result[MSB]≠a[MSB]; mode 2: A = 100…0; mode 1: 0).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → capture a, b, mode into shift registers, clear borrow chain and bit counter, go RUN. start=0 → stay.
- RUN: each cycle process bit i (i = 0..WIDTH−1) through a one-bit full subtractor: d = x⊕y⊕bin, bout = (~x&y) | (~(x⊕y)&bin).
  - mode 0/3: x = A[i], y = B[i].
  - mode 2: x = 0, y = A[i].
  - mode 1: d = ~A[i], borrow chain held at 0.
- Shift d into a result shift register; after bit WIDTH−1, load result/borrow/overflow output registers, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start while in RUN or DONE: ignored, not queued.
- Changes to a, b, mode after capture: no effect on the running operation.
- start held high continuously: a new operation begins every WIDTH+2 cycles.

## Timing
- Reset values (asynchronous, immediate): state IDLE; busy, done, result, borrow, overflow all 0; counter 0.
- Edge 0: start sampled high in IDLE; busy=1 after edge 0.
- Edges 1..WIDTH: bits 0..WIDTH−1 processed. The edge that processes bit WIDTH−1 loads the outputs and enters DONE.
- After edge WIDTH: busy=0, done=1, result/borrow/overflow carry the new values.
- Edge WIDTH+1: return to IDLE, done=0. A start sampled on that same edge is not accepted; the earliest accepted start is at edge WIDTH+2.
- Output values change only on entry to DONE; they are stable throughout RUN.
- rst mid-RUN: operation aborted; outputs clear to 0; no done pulse.
- Counter width: $clog2(WIDTH). Terminal count is WIDTH−1.

## Structure
- Package serial_sub_pkg holds:
  - the mode constants MODE_SUB=2'd0, MODE_ONES=2'd1, MODE_TWOS=2'd2, MODE_RSVD=2'd3;
  - the FSM state typedef (IDLE, RUN, DONE).
- Sub-module full_sub_bit: purely combinational. Ports x, y, bin → d, bout. It is instantiated once, and the serial loop reuses it.
- The top level holds the FSM, counter, operand shift registers, borrow flop and output registers.

## Test plan
All scenarios use WIDTH=8.
- mode 0, a=0x05, b=0x03, start pulse → done exactly 8 cycles after the start-sampling edge; result=0x02, borrow=0, overflow=0.
- mode 0, a=0x03, b=0x05 → result=0xFE, borrow=1, overflow=0. Then a=0x80, b=0x01 → result=0x7F, borrow=0, overflow=1.
- Complement modes:
  - mode 1, a=0xA5 → 0x5A, borrow=0.
  - mode 2, a=0x01 → 0xFF, borrow=1.
  - mode 2, a=0x80 → 0x80, overflow=1.
  - mode 2, a=0x00 → 0x00, borrow=0.
- Running operation protected: start 0x05−0x03, then at cycle 3 change a to 0xFF and pulse start → result still 0x02, single done pulse. With start held high → done pulses spaced 10 cycles apart.
- Reset mid-operation: rst asserted at cycle 4 of RUN → busy, done, result, borrow, overflow read 0 before the next edge; no done pulse. A fresh start then yields the correct result with normal latency.
- mode 3, a=0x10, b=0x01 → 0x0F, same as mode 0.
